// File: rtl/eq_pkg.sv
// Shared types and defaults for the equalizer sample path.
// Sample format, queue FSM states and default queue geometry.
package eq_pkg;

    localparam int EQ_DEPTH = 1024;
    localparam int EQ_TAPS  = 1021;

    typedef logic signed [15:0] smpl_t;

    typedef enum logic {IDLE, SEQ} queue_state_t;

endpackage

// File: rtl/dualport_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port, no reset.
// Latency: read data valid one clock after rd_en/rd_addr.
// Backpressure: none; accepts a write and a read every cycle.
module dualport_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sample_queue.sv
// Stereo circular sample queue: replays the newest TAPS samples oldest-first per write.
// Latency: first replayed sample two cycles after the strobe that completes the window.
// Backpressure: none; writes during a burst are stored but flag the sticky overrun.
module sample_queue
    import eq_pkg::*;
#(
    parameter int DEPTH = EQ_DEPTH,
    parameter int TAPS  = EQ_TAPS
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  wrt_smpl,
    input  smpl_t lft_smpl,
    input  smpl_t rght_smpl,
    output logic  sequencing,
    output smpl_t lft_out,
    output smpl_t rght_out,
    output logic  overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TAPS + 1);
    localparam logic [AW-1:0] TAPS_A = AW'(TAPS);
    localparam logic [CW-1:0] TAPS_C = CW'(TAPS);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    queue_state_t  state;
    logic [AW-1:0] new_ptr;
    logic [AW-1:0] new_ptr_inc;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] burst_cnt;
    logic          ram_we;
    logic          rd_en;
    logic [31:0]   rd_dat;

    assign new_ptr_inc = new_ptr + 1'b1;
    assign cnt_inc     = (cnt == TAPS_C) ? cnt : cnt + 1'b1;
    assign rd_en       = (state == SEQ);
    // A strobe coincident with reset is dropped entirely, RAM included.
    assign ram_we      = wrt_smpl & ~rst;

    dualport_ram #(
        .DEPTH (DEPTH),
        .WIDTH (32),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (new_ptr),
        .wr_dat  ({lft_smpl, rght_smpl}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_dat  (rd_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            new_ptr    <= '0;
            cnt        <= '0;
            rd_ptr     <= '0;
            burst_cnt  <= '0;
            sequencing <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Delayed read-issue flag lines up with the RAM output register.
            sequencing <= rd_en;
            if (wrt_smpl) begin
                new_ptr <= new_ptr_inc;
                cnt     <= cnt_inc;
            end
            case (state)
                IDLE: begin
                    if (wrt_smpl && (cnt_inc == TAPS_C)) begin
                        rd_ptr    <= new_ptr_inc - TAPS_A;
                        burst_cnt <= TAPS_C;
                        state     <= SEQ;
                    end
                end
                SEQ: begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    burst_cnt <= burst_cnt - 1'b1;
                    if (wrt_smpl) begin
                        overrun <= 1'b1;
                    end
                    if (burst_cnt == ONE_C) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lft_out  = sequencing ? smpl_t'(rd_dat[31:16]) : '0;
    assign rght_out = sequencing ? smpl_t'(rd_dat[15:0])  : '0;

endmodule

// File: tb/tb_sample_queue.sv
// Directed bench for sample_queue with a reduced geometry (DEPTH=16, TAPS=13)
// so pointer wrap, overrun and mid-burst reset are reached in a few hundred cycles.
module tb_sample_queue;

    localparam int DEPTH = 16;
    localparam int TAPS  = 13;

    logic                clk = 1'b0;
    logic                rst;
    logic                wrt_smpl;
    logic signed [15:0]  lft_smpl;
    logic signed [15:0]  rght_smpl;
    logic                sequencing;
    logic signed [15:0]  lft_out;
    logic signed [15:0]  rght_out;
    logic                overrun;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        int   val;        // left value written; right is its negation
        int   exp_first;  // oldest left value of the expected burst, 0 = no burst
        int   inj;        // cycle offset of an extra write during the burst, 0 = none
        logic exp_ovr;    // overrun expected after this vector
    } vec_t;

    vec_t vecs[$];

    sample_queue #(
        .DEPTH (DEPTH),
        .TAPS  (TAPS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wrt_smpl   (wrt_smpl),
        .lft_smpl   (lft_smpl),
        .rght_smpl  (rght_smpl),
        .sequencing (sequencing),
        .lft_out    (lft_out),
        .rght_out   (rght_out),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog expired");
    end

    function automatic void add_vec(input int val, input int exp_first, input int inj, input logic exp_ovr);
        vec_t t;
        t.val       = val;
        t.exp_first = exp_first;
        t.inj       = inj;
        t.exp_ovr   = exp_ovr;
        vecs.push_back(t);
    endfunction

    task automatic expect_out(input string name, input logic exp_seq, input int exp_l);
        logic signed [15:0] el;
        logic signed [15:0] er;
        el = 16'(exp_l);
        er = 16'(-exp_l);
        tests++;
        if (sequencing !== exp_seq || lft_out !== el || rght_out !== er) begin
            failed++;
            $display("FAIL %s: got seq=%0b lft=%0d rght=%0d, want seq=%0b lft=%0d rght=%0d",
                     name, sequencing, lft_out, rght_out, exp_seq, el, er);
        end
    endtask

    task automatic expect_ovr(input string name, input logic exp_ovr);
        tests++;
        if (overrun !== exp_ovr) begin
            failed++;
            $display("FAIL %s: got overrun=%0b, want %0b", name, overrun, exp_ovr);
        end
    endtask

    // Cycle c=0 carries the strobe; the burst occupies c=2..TAPS+1.
    task automatic run_write(input int val, input int exp_first, input int inj, input logic exp_ovr);
        for (int c = 0; c <= TAPS + 4; c++) begin
            @(posedge clk);
            #1;
            wrt_smpl  = (c == 0) || (inj != 0 && c == inj);
            lft_smpl  = (c == 0) ? 16'(val) : 16'(val + 1);
            rght_smpl = (c == 0) ? 16'(-val) : 16'(-(val + 1));
            @(negedge clk);
            if (exp_first != 0 && c >= 2 && c <= TAPS + 1)
                expect_out($sformatf("burst v%0d c%0d", val, c), 1'b1, exp_first + c - 2);
            else
                expect_out($sformatf("idle v%0d c%0d", val, c), 1'b0, 0);
        end
        expect_ovr($sformatf("overrun v%0d", val), exp_ovr);
    endtask

    initial begin
        rst       = 1'b1;
        wrt_smpl  = 1'b0;
        lft_smpl  = '0;
        rght_smpl = '0;

        // Window fills at write 13; every later write starts a burst of the last 13.
        for (int k = 1; k <= 30; k++)
            add_vec(k, (k >= TAPS) ? k - TAPS + 1 : 0, 0, 1'b0);
        add_vec(31, 19, 7,    1'b1);   // extra write 32 lands mid-burst
        add_vec(33, 21, 0,    1'b1);
        add_vec(34, 22, TAPS, 1'b1);   // extra write 35 on the last read-issue cycle
        add_vec(36, 24, 0,    1'b1);
        add_vec(37, 25, 0,    1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        expect_out("reset outputs", 1'b0, 0);
        expect_ovr("reset overrun", 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i])
            run_write(vecs[i].val, vecs[i].exp_first, vecs[i].inj, vecs[i].exp_ovr);

        // Reset in the middle of a burst, with a strobe in the same cycle.
        @(posedge clk);
        #1;
        wrt_smpl  = 1'b1;
        lft_smpl  = 16'(38);
        rght_smpl = 16'(-38);
        @(posedge clk);
        #1 wrt_smpl = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b1;
        wrt_smpl  = 1'b1;
        lft_smpl  = 16'(7777);
        rght_smpl = 16'(-7777);
        @(negedge clk);
        expect_out("burst before reset", 1'b1, 28);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wrt_smpl = 1'b0;
        @(negedge clk);
        expect_out("after mid-burst reset", 1'b0, 0);
        expect_ovr("overrun cleared by reset", 1'b0);

        // Only post-reset data may appear; the strobe seen with reset must not count.
        for (int j = 1; j <= TAPS; j++)
            run_write(1000 + j, (j == TAPS) ? 1001 : 0, 0, 1'b0);
        run_write(1000 + TAPS + 1, 1002, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
